program_loader: RTL and testbench

- Writer side of the program-memory interface: accepts a byte stream, writes it into the 16x8 writable program memory, and gates the processor's active-low reset.
- Processor is held in reset (cpu_rstn=0) while loading, and released only after a verified load.
- Unused addresses are padded with the HALT opcode, so a short program halts cleanly.
- Sits between a host byte source (UART receiver or testbench) and the program memory write port plus the processor's rstn.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader.sv | 170 +++++++++++++++++
 tb/tb_program_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared constants and state encoding for the program loader.
//   HALT_OPCODE is the same byte the processor decodes as halt (upper
//   nibble 1111), so padded addresses stop execution cleanly.
package program_loader_pkg;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 16;
   localparam int MAX_LEN = 16;

   localparam logic [7:0] HALT_OPCODE = 8'hF0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_PAD  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the program memory. Accepts a framed byte stream
//   (length N, N payload bytes, 8-bit checksum of the payload), writes the
//   payload to memory, pads the rest with PAD_WORD and keeps the processor
//   in reset until a verified load completes.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      one-cycle pulse, starts a load from IDLE/DONE/ERR
//   i_in_valid   stream byte valid
//   i_in_data    stream byte
//   o_in_ready   loader accepts a byte (transfer = valid && ready)
//   o_mem_we     program memory write enable (registered)
//   o_mem_addr   program memory write address (registered)
//   o_mem_wdata  program memory write data (registered)
//   o_cpu_rstn   active-low processor reset, high only in DONE
//   o_busy       high in LEN/DATA/CSUM/PAD
//   o_done       high in DONE
//   o_err        high in ERR
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | waiting for the length byte
// DATA  | accepting payload bytes, one write per byte
// CSUM  | waiting for the checksum byte
// PAD   | filling unloaded addresses with PAD_WORD, one per cycle
// DONE  | verified load, processor released
// ERR   | bad length or checksum, processor held in reset
module program_loader
   import program_loader_pkg::*;
#(
   parameter int               P_ADDR_W   = ADDR_W,
   parameter int               P_DATA_W   = DATA_W,
   parameter int               P_DEPTH    = DEPTH,
   parameter logic [P_DATA_W-1:0] PAD_WORD = HALT_OPCODE
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_in_valid,
   input  logic [P_DATA_W-1:0] i_in_data,
   output logic                o_in_ready,
   output logic                o_mem_we,
   output logic [P_ADDR_W-1:0] o_mem_addr,
   output logic [P_DATA_W-1:0] o_mem_wdata,
   output logic                o_cpu_rstn,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
);

   localparam logic [P_DATA_W-1:0] W_MAX_LEN  = P_DATA_W'(P_DEPTH);
   localparam logic [P_ADDR_W:0]   W_FULL_LEN = (P_ADDR_W+1)'(P_DEPTH);
   localparam logic [P_ADDR_W-1:0] W_LAST_ADR = P_ADDR_W'(P_DEPTH - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   // count and len are one bit wider than the address so N==16 is representable
   logic [P_ADDR_W:0]     r_count;
   logic [P_ADDR_W:0]     r_len;
   logic [P_DATA_W-1:0]   r_csum;
   logic                  r_in_ready;
   logic                  r_mem_we;
   logic [P_ADDR_W-1:0]   r_mem_addr;
   logic [P_DATA_W-1:0]   r_mem_wdata;
   logic                  r_cpu_rstn;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  w_xfer;

   assign w_xfer = i_in_valid && r_in_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) w_state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (w_xfer) begin
               if (i_in_data == '0 || i_in_data > W_MAX_LEN) w_state_nxt = ST_ERR;
               else                                          w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_xfer && (r_count == r_len - 1'b1)) w_state_nxt = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_xfer) begin
               if (i_in_data != r_csum)      w_state_nxt = ST_ERR;
               else if (r_len == W_FULL_LEN) w_state_nxt = ST_DONE;
               else                          w_state_nxt = ST_PAD;
            end
         end
         ST_PAD: begin
            if (r_count[P_ADDR_W-1:0] == W_LAST_ADR) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_len       <= '0;
         r_csum      <= '0;
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_rstn  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // status flags are registered from the next state so they line up
         // with the state register itself
         r_in_ready <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA) ||
                       (w_state_nxt == ST_CSUM);
         r_busy     <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA) ||
                       (w_state_nxt == ST_CSUM) || (w_state_nxt == ST_PAD);
         r_done     <= (w_state_nxt == ST_DONE);
         r_err      <= (w_state_nxt == ST_ERR);
         r_cpu_rstn <= (w_state_nxt == ST_DONE);
         r_mem_we   <= 1'b0;

         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (i_start) begin
                  r_count <= '0;
                  r_csum  <= '0;
               end
            end
            ST_LEN: begin
               if (w_xfer) r_len <= i_in_data[P_ADDR_W:0];
            end
            ST_DATA: begin
               if (w_xfer) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_count[P_ADDR_W-1:0];
                  r_mem_wdata <= i_in_data;
                  r_csum      <= r_csum + i_in_data;
                  r_count     <= r_count + 1'b1;
               end
            end
            ST_PAD: begin
               r_mem_we    <= 1'b1;
               r_mem_addr  <= r_count[P_ADDR_W-1:0];
               r_mem_wdata <= PAD_WORD;
               if (r_count[P_ADDR_W-1:0] != W_LAST_ADR) r_count <= r_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_cpu_rstn  = r_cpu_rstn;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, mem_we, cpu_rstn, busy, done, err;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem_model [16];
   logic [3:0] log_addr  [64];
   int         wr_cnt = 0;

   typedef struct packed {
      logic [4:0]       nbytes;
      logic [17:0][7:0] bytes;
      logic             exp_err;
      logic [4:0]       exp_writes;
      logic [4:0]       exp_lat;
   } vec_t;

   vec_t vecs [6];

   program_loader dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_cpu_rstn  (cpu_rstn),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 64) log_addr[wr_cnt] = mem_addr;
         mem_model[mem_addr] = mem_wdata;
         wr_cnt++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_cnt = 0;
      for (int a = 0; a < 16; a++) mem_model[a] = 8'hxx;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_cpu_rstn", int'(cpu_rstn), 0);
      check("start_done",     int'(done),     0);
      check("start_err",      int'(err),      0);
      check("start_ready",    int'(in_ready), 1);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready stayed %0d expected 1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // counts cycles from the last transfer until done or err appears
   task automatic wait_end(output int lat);
      lat = 0;
      while (!(done || err) && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!(done || err)) begin
         n_checks++;
         n_errors++;
         $display("FAIL end_timeout: done=%0d err=%0d expected one set", done, err);
      end
   endtask

   task automatic check_result(input vec_t v, input int lat);
      int n;
      logic [7:0] exp;
      check("lat",      lat,            int'(v.exp_lat));
      check("err",      int'(err),      int'(v.exp_err));
      check("done",     int'(done),     int'(!v.exp_err));
      check("cpu_rstn", int'(cpu_rstn), int'(!v.exp_err));
      check("busy_end", int'(busy),     0);
      repeat (3) @(posedge clk);
      #1;
      check("writes",   wr_cnt,         int'(v.exp_writes));
      for (int k = 0; k < wr_cnt && k < 64; k++)
         check("wr_order", int'(log_addr[k]), k);
      if (!v.exp_err) begin
         n = int'(v.bytes[0]);
         for (int a = 0; a < 16; a++) begin
            exp = (a < n) ? v.bytes[a+1] : 8'hF0;
            check("mem", int'(mem_model[a]), int'(exp));
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      clear_log();
      pulse_start();
      for (int i = 0; i < int'(v.nbytes); i++) send(v.bytes[i]);
      wait_end(lat);
      check_result(v, lat);
   endtask

   initial begin
      int lat;
      logic [7:0] s;

      // 0: N=3, pads addresses 3..15
      vecs[0] = '0;
      vecs[0].nbytes = 5;
      vecs[0].bytes[0] = 8'h03; vecs[0].bytes[1] = 8'h11; vecs[0].bytes[2] = 8'h22;
      vecs[0].bytes[3] = 8'h33; vecs[0].bytes[4] = 8'h66;
      vecs[0].exp_err = 0; vecs[0].exp_writes = 16; vecs[0].exp_lat = 13;
      // 1: N=16, payload 00..0F, checksum 0x78, no padding
      vecs[1] = '0;
      vecs[1].nbytes = 18;
      vecs[1].bytes[0] = 8'h10;
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
         vecs[1].bytes[i+1] = s;
         s = s + 8'h01;
      end
      vecs[1].bytes[17] = 8'h78;
      vecs[1].exp_err = 0; vecs[1].exp_writes = 16; vecs[1].exp_lat = 0;
      // 2: reload from DONE with N=1 payload F0
      vecs[2] = '0;
      vecs[2].nbytes = 3;
      vecs[2].bytes[0] = 8'h01; vecs[2].bytes[1] = 8'hF0; vecs[2].bytes[2] = 8'hF0;
      vecs[2].exp_err = 0; vecs[2].exp_writes = 16; vecs[2].exp_lat = 15;
      // 3: bad checksum (0C vs 0B)
      vecs[3] = '0;
      vecs[3].nbytes = 4;
      vecs[3].bytes[0] = 8'h02; vecs[3].bytes[1] = 8'h05; vecs[3].bytes[2] = 8'h06;
      vecs[3].bytes[3] = 8'h0C;
      vecs[3].exp_err = 1; vecs[3].exp_writes = 2; vecs[3].exp_lat = 0;
      // 4: length 0
      vecs[4] = '0;
      vecs[4].nbytes = 1; vecs[4].bytes[0] = 8'h00;
      vecs[4].exp_err = 1; vecs[4].exp_writes = 0; vecs[4].exp_lat = 0;
      // 5: length 17
      vecs[5] = '0;
      vecs[5].nbytes = 1; vecs[5].bytes[0] = 8'h11;
      vecs[5].exp_err = 1; vecs[5].exp_writes = 0; vecs[5].exp_lat = 0;

      clear_log();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_outputs", int'({in_ready, mem_we, cpu_rstn, busy, done, err}), 0);
      check("rst_addr",    int'(mem_addr),  0);
      check("rst_wdata",   int'(mem_wdata), 0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_ready", int'(in_ready), 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // valid toggling with a start pulse in the middle of DATA
      clear_log();
      pulse_start();
      send(8'h03);
      send(8'h11);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mid_start_busy", int'(busy), 1);
      check("mid_start_done", int'(done), 0);
      send(8'h22);
      @(posedge clk);
      #1;
      send(8'h33);
      @(posedge clk);
      #1;
      send(8'h66);
      wait_end(lat);
      check_result(vecs[0], lat);

      // reset in the middle of a load
      clear_log();
      pulse_start();
      send(8'h03);
      send(8'h11);
      send(8'h22);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_outputs", int'({in_ready, mem_we, cpu_rstn, busy, done, err}), 0);
      check("midrst_addr",    int'(mem_addr),  0);
      check("midrst_wdata",   int'(mem_wdata), 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_writes", wr_cnt, 2);
      check("midrst_ready",  int'(in_ready), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
